// File: rtl/posit_pkg.sv
// posit_pkg -- shared definitions for the posit operand decoder.
//   N_DEF / ES_DEF : default posit word width and exponent field width
//   fw_of()        : fraction width (hidden bit excluded) = n - es - 3
//   sw_of()        : signed scale width = clog2(n) + es + 1
//   dec_state_t    : decoder FSM states
package posit_pkg;

  localparam int N_DEF  = 16;
  localparam int ES_DEF = 3;

  function automatic int fw_of(input int n, input int es);
    return n - es - 3;
  endfunction

  function automatic int sw_of(input int n, input int es);
    return $clog2(n) + es + 1;
  endfunction

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SCAN    = 2'd1,
    EXTRACT = 2'd2,
    DONE    = 2'd3
  } dec_state_t;

endpackage

// File: rtl/posit_abs.sv
// posit_abs -- conditional two's-complement negate (combinational).
//   a   : N-bit input word
//   neg : when high, y = -a; otherwise y = a
//   y   : N-bit result
module posit_abs #(
  parameter int N = 16
) (
  input  logic [N-1:0] a,
  input  logic         neg,
  output logic [N-1:0] y
);

  assign y = neg ? (~a + N'(1)) : a;

endmodule

// File: rtl/posit_decoder_seq.sv
// posit_decoder_seq -- sequential posit operand decoder for a multiplier.
// Splits a raw posit into sign / zero / NaR flags, a signed scale
// (k*2^ES + e) and a left-aligned fraction. The regime run is scanned one
// bit per cycle, so latency depends on the regime length.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; the producer holds its data stable until that edge, and the
// consumer's ready never depends combinationally on its own valid.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     operand handshake (in_posit = raw posit word)
//   out_valid/out_ready   result handshake
//   out_sign/out_zero/out_nar/out_scale/out_frac   decoded fields
//   dec_count             completed result handshakes, saturating
//                         (present only when POSIT_DEC_STATS_EN is defined)
//   dbg_state             current FSM state (dec_state_t encoding)
module posit_decoder_seq
  import posit_pkg::*;
#(
  parameter int  N  = N_DEF,
  parameter int  ES = ES_DEF,
  localparam int FW = fw_of(N, ES),
  localparam int SW = sw_of(N, ES)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_posit,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_sign,
  output logic          out_zero,
  output logic          out_nar,
  output logic [SW-1:0] out_scale,
  output logic [FW-1:0] out_frac,
`ifdef POSIT_DEC_STATS_EN
  output logic [15:0]   dec_count,
`endif
  output logic [1:0]    dbg_state
);

  localparam int MW = $clog2(N);  // run-length counter width (holds N-1)
  localparam int WW = N - 1;      // work register: posit without sign bit

  dec_state_t    state, state_nxt;
  logic [WW-1:0] work;
  logic [MW-1:0] run_len;
  logic          regime_bit;

  logic [N-1:0]  abs_val;
  logic          in_zero, in_nar, special;
  logic          accept, handoff, run_end;
  logic [ES-1:0] exp_field;
  logic [FW-1:0] frac_field;
  logic [SW-1:0] m_ext, k_val, scale_val;

  posit_abs #(.N(N)) u_abs (
    .a   (in_posit),
    .neg (in_posit[N-1]),
    .y   (abs_val)
  );

  // NaR is the only nonzero word whose negation keeps the MSB set.
  assign in_zero = (in_posit == '0);
  assign in_nar  = abs_val[N-1];
  assign special = in_zero | in_nar;

  assign in_ready  = (state == IDLE) | ((state == DONE) & out_ready);
  assign accept    = in_valid & in_ready;
  assign out_valid = (state == DONE);
  assign handoff   = out_valid & out_ready;
  assign dbg_state = state;

  // The MSB of work always belongs to the run; the run ends when the bit
  // below it differs or when the whole word has been consumed.
  assign run_end = (work[WW-2] != regime_bit) || (run_len == MW'(WW - 1));

  // In EXTRACT the terminating bit sits at the MSB (or work is all zero
  // after a full-word run), so exponent and fraction start just below it.
  // Bits shifted in from the bottom are zero, giving the padding for free.
  assign exp_field  = work[WW-2 -: ES];
  assign frac_field = work[WW-2-ES -: FW];

  assign m_ext     = SW'(run_len);
  assign k_val     = regime_bit ? (m_ext - SW'(1)) : (SW'(0) - m_ext);
  assign scale_val = (k_val << ES) + SW'(exp_field);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = special ? DONE : SCAN;
      SCAN:    if (run_end) state_nxt = EXTRACT;
      EXTRACT: state_nxt = DONE;
      DONE: begin
        if (handoff) begin
          if (in_valid) state_nxt = special ? DONE : SCAN;
          else          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work       <= '0;
      run_len    <= '0;
      regime_bit <= 1'b0;
      out_sign   <= 1'b0;
      out_zero   <= 1'b0;
      out_nar    <= 1'b0;
      out_scale  <= '0;
      out_frac   <= '0;
    end else if (accept) begin
      work       <= abs_val[N-2:0];
      regime_bit <= abs_val[N-2];
      run_len    <= '0;
      out_sign   <= in_posit[N-1] & ~in_nar;
      out_zero   <= in_zero;
      out_nar    <= in_nar;
      out_scale  <= '0;
      out_frac   <= '0;
    end else if (state == SCAN) begin
      run_len <= run_len + MW'(1);
      work    <= work << 1;
    end else if (state == EXTRACT) begin
      out_scale <= scale_val;
      out_frac  <= frac_field;
    end
  end

`ifdef POSIT_DEC_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               dec_count <= '0;
    else if (handoff && dec_count != 16'hFFFF) dec_count <= dec_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_posit_decoder_seq.sv
// tb_posit_decoder_seq -- bench for posit_decoder_seq (N=16, ES=3).
// Directed operands use literal expectations; random operands are checked
// against a bit-walking reference decoder written from the posit rules.
module tb_posit_decoder_seq;
  import posit_pkg::*;

  localparam int N  = 16;
  localparam int ES = 3;
  localparam int FW = N - ES - 3;
  localparam int SW = $clog2(N) + ES + 1;
  localparam int EW = 3 + SW + FW + 8;  // {zero, nar, sign, scale, frac, latency}

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_posit;
  logic          out_valid;
  logic          out_ready;
  logic          out_sign;
  logic          out_zero;
  logic          out_nar;
  logic [SW-1:0] out_scale;
  logic [FW-1:0] out_frac;
  logic [1:0]    dbg_state;
`ifdef POSIT_DEC_STATS_EN
  logic [15:0]   dec_count;
`endif

  int tests  = 0;
  int fails  = 0;
  int hs_cnt = 0;
  logic [EW-1:0] exp_q[$];

  posit_decoder_seq #(.N(N), .ES(ES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_posit  (in_posit),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sign  (out_sign),
    .out_zero  (out_zero),
    .out_nar   (out_nar),
    .out_scale (out_scale),
    .out_frac  (out_frac),
`ifdef POSIT_DEC_STATS_EN
    .dec_count (dec_count),
`endif
    .dbg_state (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  function automatic logic [EW-1:0] pack(input logic z, input logic nr, input logic s,
                                         input logic [SW-1:0] sc, input logic [FW-1:0] f,
                                         input int lat);
    return {z, nr, s, sc, f, 8'(lat)};
  endfunction

  function automatic string fmt(input logic [EW-1:0] x);
    return $sformatf("zero=%0b nar=%0b sign=%0b scale=%0d frac=%b lat=%0d",
                     x[EW-1], x[EW-2], x[EW-3], $signed(x[EW-4 -: SW]),
                     x[FW+7 -: FW], x[7:0]);
  endfunction

  // Reference decoder: walk the bits of |p| below the sign, count the regime
  // run, skip the terminator, then read ES exponent bits and FW fraction bits
  // (bits past the end of the word read as zero).
  function automatic logic [EW-1:0] model(input logic [N-1:0] p);
    int v, r, m, i, k, e, f, sc;
    if (p == '0) return pack(1'b1, 1'b0, 1'b0, '0, '0, 1);
    if (p == {1'b1, {(N-1){1'b0}}}) return pack(1'b0, 1'b1, 1'b0, '0, '0, 1);
    v = p[N-1] ? ((1 << N) - int'(p)) : int'(p);
    r = (v >> (N-2)) & 1;
    i = N - 2;
    m = 0;
    while (i >= 0 && ((v >> i) & 1) == r) begin
      m++;
      i--;
    end
    k = (r == 1) ? (m - 1) : -m;
    i--;
    e = 0;
    for (int j = 0; j < ES; j++) begin
      e = 2 * e + ((i >= 0) ? ((v >> i) & 1) : 0);
      i--;
    end
    f = 0;
    for (int j = 0; j < FW; j++) begin
      f = 2 * f + ((i >= 0) ? ((v >> i) & 1) : 0);
      i--;
    end
    sc = k * (1 << ES) + e;
    return pack(1'b0, 1'b0, p[N-1], SW'(sc), FW'(f), m + 2);
  endfunction

  // ---------------- driver tasks ----------------
  // Presents p, waits for acceptance, records the expectation. Returns 1 time
  // unit after the accepting edge with in_valid dropped.
  task automatic send(input logic [N-1:0] p, input logic [EW-1:0] exp);
    int waitc;
    waitc = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_posit = p;
    #1;
    while (!in_ready && waitc < 50) begin
      @(negedge clk);
      #1;
      waitc++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL send_ready: in_ready stayed %0b for operand %h, required 1", in_ready, p);
    end
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_posit = '0;
  endtask

  // Waits for out_valid (latency counted from start_lat) and checks the result.
  task automatic collect(input string tag, input int start_lat, output logic [EW-1:0] exp_o);
    logic [EW-1:0] exp, got;
    int lat;
    exp   = exp_q.pop_front();
    exp_o = exp;
    lat   = start_lat;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    got = pack(out_zero, out_nar, out_sign, out_scale, out_frac, lat);
    tests++;
    if (!out_valid) begin
      fails++;
      $display("FAIL %s timeout: out_valid=0 after %0d cycles, required 1 with %s", tag, lat, fmt(exp));
    end else if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %s, required %s", tag, fmt(got), fmt(exp));
    end
  endtask

  // Completes the output handshake, optionally stalling with random out_ready.
  task automatic consume(input string tag, input bit rand_ready, input logic [EW-1:0] exp);
    logic [EW-1:0] got;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      out_ready = (!rand_ready || i == 19) ? 1'b1 : 1'($urandom_range(0, 1));
      #1;
      if (out_ready) begin
        @(posedge clk);
        #1;
        hs_cnt++;
        tests++;
        if (out_valid !== 1'b0) begin
          fails++;
          $display("FAIL %s release: out_valid=%0b after handshake, required 0", tag, out_valid);
        end
`ifdef POSIT_DEC_STATS_EN
        tests++;
        if (dec_count !== 16'(hs_cnt)) begin
          fails++;
          $display("FAIL %s dec_count: got %0d, required %0d", tag, dec_count, hs_cnt);
        end
`endif
        break;
      end else begin
        got = pack(out_zero, out_nar, out_sign, out_scale, out_frac, 0);
        tests++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || got[EW-1:8] !== exp[EW-1:8]) begin
          fails++;
          $display("FAIL %s stall: out_valid=%0b in_ready=%0b %s, required out_valid=1 in_ready=0 %s",
                   tag, out_valid, in_ready, fmt(got), fmt(exp));
        end
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_posit  = '0;
    out_ready = 1'b1;
    #3;
    tests++;
    if (out_valid !== 1'b0 || {out_sign, out_zero, out_nar} !== 3'b000 ||
        out_scale !== '0 || out_frac !== '0) begin
      fails++;
      $display("FAIL reset_outputs: out_valid=%0b s/z/n=%b scale=%h frac=%h, required all 0",
               out_valid, {out_sign, out_zero, out_nar}, out_scale, out_frac);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || dbg_state !== 2'(IDLE)) begin
      fails++;
      $display("FAIL reset_release: in_ready=%0b out_valid=%0b state=%0d, required 1 0 %0d",
               in_ready, out_valid, dbg_state, 2'(IDLE));
    end
`ifdef POSIT_DEC_STATS_EN
    tests++;
    if (dec_count !== 16'd0) begin
      fails++;
      $display("FAIL reset_dec_count: got %0d, required 0", dec_count);
    end
`endif
  endtask

  task automatic test_directed();
    logic [N-1:0]  dp[6];
    logic [EW-1:0] de[6];
    logic [EW-1:0] ex;
    dp[0] = 16'h4200; de[0] = pack(1'b0, 1'b0, 1'b0, SW'(0),    10'b1000000000, 3);
    dp[1] = 16'hC000; de[1] = pack(1'b0, 1'b0, 1'b1, SW'(0),    10'b0,          3);
    dp[2] = 16'h0000; de[2] = pack(1'b1, 1'b0, 1'b0, SW'(0),    10'b0,          1);
    dp[3] = 16'h8000; de[3] = pack(1'b0, 1'b1, 1'b0, SW'(0),    10'b0,          1);
    dp[4] = 16'h0001; de[4] = pack(1'b0, 1'b0, 1'b0, SW'(-112), 10'b0,          16);
    dp[5] = 16'h7FFF; de[5] = pack(1'b0, 1'b0, 1'b0, SW'(112),  10'b0,          17);
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      send(dp[i], de[i]);
      collect($sformatf("directed_%h", dp[i]), 1, ex);
      consume($sformatf("directed_%h", dp[i]), 1'b0, ex);
    end
  endtask

  task automatic test_random();
    logic [N-1:0]  p;
    logic [EW-1:0] ex;
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 15))
        0:       p = '0;
        1:       p = 16'h8000;
        default: p = N'($urandom_range(0, 16'hFFFF));
      endcase
      send(p, model(p));
      collect($sformatf("random_%0d_%h", i, p), 1, ex);
      consume($sformatf("random_%0d_%h", i, p), 1'b1, ex);
    end
  endtask

  task automatic test_ignore_busy();
    logic [EW-1:0] ex;
    int lat;
    out_ready = 1'b1;
    send(16'h0001, model(16'h0001));
    in_valid = 1'b1;
    in_posit = 16'h4200;
    lat = 1;
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
        fails++;
        $display("FAIL ignore_busy: in_ready=%0b out_valid=%0b during scan, required 0 0", in_ready, out_valid);
      end
      @(posedge clk);
      #1;
      lat++;
    end
    in_valid = 1'b0;
    collect("ignore_busy_result", lat, ex);
    consume("ignore_busy_result", 1'b0, ex);
  endtask

  task automatic test_back_to_back();
    logic [EW-1:0] ex, got;
    logic [EW-1:0] e42;
    e42 = pack(1'b0, 1'b0, 1'b0, SW'(0), 10'b1000000000, 3);
    out_ready = 1'b0;
    send(16'h4200, e42);
    collect("b2b_first", 1, ex);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_posit = 16'h7FFF;
      #1;
      got = pack(out_zero, out_nar, out_sign, out_scale, out_frac, 0);
      tests++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || got[EW-1:8] !== e42[EW-1:8]) begin
        fails++;
        $display("FAIL b2b_hold_%0d: out_valid=%0b in_ready=%0b %s, required 1 0 %s",
                 i, out_valid, in_ready, fmt(got), fmt(e42));
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    in_posit  = 16'h4200;
    exp_q.push_back(e42);
    #1;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL b2b_ready: in_ready=%0b with out_ready high in DONE, required 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    hs_cnt++;
    tests++;
    if (out_valid !== 1'b0 || dbg_state !== 2'(SCAN)) begin
      fails++;
      $display("FAIL b2b_handoff: out_valid=%0b state=%0d, required 0 %0d", out_valid, dbg_state, 2'(SCAN));
    end
`ifdef POSIT_DEC_STATS_EN
    tests++;
    if (dec_count !== 16'(hs_cnt)) begin
      fails++;
      $display("FAIL b2b_dec_count: got %0d, required %0d", dec_count, hs_cnt);
    end
`endif
    collect("b2b_second", 1, ex);
    consume("b2b_second", 1'b0, ex);
  endtask

  task automatic test_reset_mid_scan();
    logic [EW-1:0] ex;
    // Reset while a signed result is held in DONE clears it at once.
    out_ready = 1'b0;
    send(16'hC000, pack(1'b0, 1'b0, 1'b1, SW'(0), 10'b0, 3));
    collect("pre_reset_done", 1, ex);
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (out_valid !== 1'b0 || out_sign !== 1'b0) begin
      fails++;
      $display("FAIL reset_in_done: out_valid=%0b out_sign=%0b, required 0 0", out_valid, out_sign);
    end
    hs_cnt = 0;
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    // Reset in the middle of a long regime scan.
    out_ready = 1'b1;
    send(16'h0001, model(16'h0001));
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || dbg_state !== 2'(IDLE) ||
        {out_sign, out_zero, out_nar} !== 3'b000 || out_scale !== '0 || out_frac !== '0) begin
      fails++;
      $display("FAIL reset_mid_scan: out_valid=%0b in_ready=%0b state=%0d s/z/n=%b scale=%h frac=%h, required 0 1 0 000 0 0",
               out_valid, in_ready, dbg_state, {out_sign, out_zero, out_nar}, out_scale, out_frac);
    end
    exp_q.delete();
    hs_cnt = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    send(16'h4200, pack(1'b0, 1'b0, 1'b0, SW'(0), 10'b1000000000, 3));
    collect("after_reset_4200", 1, ex);
    consume("after_reset_4200", 1'b0, ex);
  endtask

  // ---------------- main ----------------
  initial begin
    test_reset();
    test_directed();
    test_ignore_busy();
    test_back_to_back();
    test_random();
    test_reset_mid_scan();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
